// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, exception codes, vectors and exc_req layout.
// Also holds the fixed-priority exception code encoder.
package cp0_pkg;

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;

    localparam logic [31:0] VEC_BEV    = 32'hBFC0_0380;
    localparam logic [31:0] VEC_NORMAL = 32'h8000_0180;

    localparam int EXC_REQ_W    = 7;
    localparam int EXC_BIT_INT  = 6;
    localparam int EXC_BIT_ADEL = 5;
    localparam int EXC_BIT_ADES = 4;
    localparam int EXC_BIT_SYS  = 3;
    localparam int EXC_BIT_BP   = 2;
    localparam int EXC_BIT_RI   = 1;
    localparam int EXC_BIT_OV   = 0;

    // Highest set bit wins; an all-zero request is never consumed by the caller.
    function automatic logic [4:0] exc_code_of(input logic [EXC_REQ_W-1:0] req);
        if (req[EXC_BIT_INT])       return EXC_INT;
        else if (req[EXC_BIT_ADEL]) return EXC_ADEL;
        else if (req[EXC_BIT_ADES]) return EXC_ADES;
        else if (req[EXC_BIT_SYS])  return EXC_SYS;
        else if (req[EXC_BIT_BP])   return EXC_BP;
        else if (req[EXC_BIT_RI])   return EXC_RI;
        else                        return EXC_OV;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 timer: prescale divider, Count, Compare and the sticky timer interrupt TI.
// Write strobes arrive already qualified against exceptions and eret.
module cp0_timer
    import cp0_pkg::*;
#(
    parameter int COUNT_DIV = 2,
    parameter int TIMER_EN  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_wen,
    input  logic        compare_wen,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    localparam int             DIV_W    = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

    logic [DIV_W-1:0] div;
    logic             div_wrap;
    logic             ti_hit;

    assign div_wrap = (div == DIV_LAST);
    assign ti_hit   = (TIMER_EN != 0) && (count == compare);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div     <= '0;
            count   <= '0;
            compare <= '0;
            ti      <= 1'b0;
        end else begin
            if (count_wen) begin
                count <= wdata;
                div   <= '0;
            end else if (div_wrap) begin
                count <= count + 32'd1;
                div   <= '0;
            end else begin
                div <= div + 1'b1;
            end

            if (compare_wen) begin
                compare <= wdata;
            end

            // Acknowledging via Compare must win over a coincident match.
            if (compare_wen) begin
                ti <= 1'b0;
            end else if (ti_hit) begin
                ti <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_unit.sv
// MIPS CP0 at the commit stage: exception entry/exit, mtc0/mfc0, interrupt lines
// and the flush target. Timer state lives in cp0_timer.
module cp0_unit
    import cp0_pkg::*;
#(
    parameter int NUM_HW_INT = 6,
    parameter int COUNT_DIV  = 2,
    parameter int TIMER_EN   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4:0]            cp0_addr,
    input  logic                  cp0_wen,
    input  logic [31:0]           cp0_wdata,
    output logic [31:0]           cp0_rdata,
    input  logic [EXC_REQ_W-1:0]  exc_req,
    input  logic                  eret,
    input  logic [31:0]           exc_pc,
    input  logic                  is_slot,
    input  logic [31:0]           bad_vaddr,
    input  logic [NUM_HW_INT-1:0] hw_int,
    output logic                  int_pending,
    output logic                  flush,
    output logic [31:0]           flush_pc
);

    localparam logic STATUS_BEV = 1'b1;

    logic [7:0]  status_im;
    logic        status_exl;
    logic        status_ie;
    logic        cause_bd;
    logic [4:0]  cause_exc;
    logic [1:0]  cause_ip_sw;
    logic [5:0]  cause_ip_hw;
    logic [31:0] epc;
    logic [31:0] badvaddr;

    logic [31:0] count;
    logic [31:0] compare;
    logic        ti;

    logic        exc_take;
    logic        mtc0_take;
    logic        wr_status;
    logic        wr_cause;
    logic        wr_epc;
    logic        wr_count;
    logic        wr_compare;
    logic [4:0]  exc_code;
    logic        addr_fault;
    logic [5:0]  hw_int_ext;
    logic [7:0]  cause_ip;
    logic [31:0] status_rd;
    logic [31:0] cause_rd;

    // Exceptions beat eret, which beats mtc0; a losing write has no effect at all.
    assign exc_take   = |exc_req;
    assign mtc0_take  = cp0_wen & ~exc_take & ~eret;
    assign wr_status  = mtc0_take && (cp0_addr == REG_STATUS);
    assign wr_cause   = mtc0_take && (cp0_addr == REG_CAUSE);
    assign wr_epc     = mtc0_take && (cp0_addr == REG_EPC);
    assign wr_count   = mtc0_take && (cp0_addr == REG_COUNT);
    assign wr_compare = mtc0_take && (cp0_addr == REG_COMPARE);

    assign exc_code   = exc_code_of(exc_req);
    assign addr_fault = ~exc_req[EXC_BIT_INT] & (exc_req[EXC_BIT_ADEL] | exc_req[EXC_BIT_ADES]);
    assign hw_int_ext = 6'(hw_int);

    cp0_timer #(
        .COUNT_DIV(COUNT_DIV),
        .TIMER_EN (TIMER_EN)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_wen  (wr_count),
        .compare_wen(wr_compare),
        .wdata      (cp0_wdata),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status_im   <= '0;
            status_exl  <= 1'b0;
            status_ie   <= 1'b0;
            cause_bd    <= 1'b0;
            cause_exc   <= '0;
            cause_ip_sw <= '0;
            cause_ip_hw <= '0;
            epc         <= '0;
            badvaddr    <= '0;
        end else begin
            cause_ip_hw <= hw_int_ext;
            if (exc_take) begin
                status_exl <= 1'b1;
                cause_exc  <= exc_code;
                // Nested exceptions keep the original return point.
                if (!status_exl) begin
                    epc      <= is_slot ? (exc_pc - 32'd4) : exc_pc;
                    cause_bd <= is_slot;
                end
                if (addr_fault) begin
                    badvaddr <= bad_vaddr;
                end
            end else if (eret) begin
                status_exl <= 1'b0;
            end else begin
                if (wr_status) begin
                    status_im  <= cp0_wdata[15:8];
                    status_exl <= cp0_wdata[1];
                    status_ie  <= cp0_wdata[0];
                end
                if (wr_cause) begin
                    cause_ip_sw <= cp0_wdata[9:8];
                end
                if (wr_epc) begin
                    epc <= cp0_wdata;
                end
            end
        end
    end

    assign cause_ip  = {cause_ip_hw[5] | ti, cause_ip_hw[4:0], cause_ip_sw};
    assign status_rd = {9'b0, STATUS_BEV, 6'b0, status_im, 6'b0, status_exl, status_ie};
    assign cause_rd  = {cause_bd, ti, 14'b0, cause_ip, 1'b0, cause_exc, 2'b0};

    always_comb begin
        cp0_rdata = 32'h0;
        case (cp0_addr)
            REG_BADVADDR: cp0_rdata = badvaddr;
            REG_COUNT:    cp0_rdata = count;
            REG_COMPARE:  cp0_rdata = compare;
            REG_STATUS:   cp0_rdata = status_rd;
            REG_CAUSE:    cp0_rdata = cause_rd;
            REG_EPC:      cp0_rdata = epc;
            default:      cp0_rdata = 32'h0;
        endcase
    end

    assign int_pending = status_ie & ~status_exl & (|(cause_ip & status_im));
    assign flush       = exc_take | eret;
    assign flush_pc    = exc_take ? (STATUS_BEV ? VEC_BEV : VEC_NORMAL) : epc;

endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit with hand-computed expected register values.
module tb_cp0_unit;

    logic        clk;
    logic        rst;
    logic [4:0]  cp0_addr;
    logic        cp0_wen;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic [6:0]  exc_req;
    logic        eret;
    logic [31:0] exc_pc;
    logic        is_slot;
    logic [31:0] bad_vaddr;
    logic [5:0]  hw_int;
    logic        int_pending;
    logic        flush;
    logic [31:0] flush_pc;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] rv;

    cp0_unit #(.NUM_HW_INT(6), .COUNT_DIV(2), .TIMER_EN(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .cp0_addr   (cp0_addr),
        .cp0_wen    (cp0_wen),
        .cp0_wdata  (cp0_wdata),
        .cp0_rdata  (cp0_rdata),
        .exc_req    (exc_req),
        .eret       (eret),
        .exc_pc     (exc_pc),
        .is_slot    (is_slot),
        .bad_vaddr  (bad_vaddr),
        .hw_int     (hw_int),
        .int_pending(int_pending),
        .flush      (flush),
        .flush_pc   (flush_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        cp0_addr = a;
        #1;
        d = cp0_rdata;
    endtask

    task automatic rd_check(input string tag, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        check(tag, d, exp);
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        cp0_addr  = a;
        cp0_wdata = d;
        cp0_wen   = 1'b1;
        step();
        cp0_wen   = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        cp0_addr = 5'd0; cp0_wen = 1'b0; cp0_wdata = 32'h0;
        exc_req = 7'h0; eret = 1'b0; exc_pc = 32'h0; is_slot = 1'b0;
        bad_vaddr = 32'h0; hw_int = 6'h0;
        #12 rst = 1'b1;
        step();

        // 1: dirty the state, then assert reset asynchronously mid-cycle
        mtc0(5'd12, 32'h0000_FF01);
        mtc0(5'd13, 32'h0000_0300);
        rd_check("pre_status", 5'd12, 32'h0040_FF01);
        check("pre_intp", {31'b0, int_pending}, 32'h1);
        #2 rst = 1'b0;
        #1;
        rd_check("rst_status", 5'd12, 32'h0040_0000);
        rd_check("rst_cause", 5'd13, 32'h0);
        check("rst_intp", {31'b0, int_pending}, 32'h0);
        @(negedge clk) rst = 1'b1;
        step();

        // 2: ri+sys in a delay slot, sys wins
        exc_req = 7'b000_1010; exc_pc = 32'hBFC0_0100; is_slot = 1'b1;
        #1;
        check("exc_flush", {31'b0, flush}, 32'h1);
        check("exc_vec", flush_pc, 32'hBFC0_0380);
        step();
        exc_req = 7'h0; is_slot = 1'b0;
        rd_check("sys_epc", 5'd14, 32'hBFC0_00FC);
        rd(5'd13, rv);
        check("sys_code", {27'b0, rv[6:2]}, 32'h08);
        check("sys_bd", {31'b0, rv[31]}, 32'h1);
        rd_check("sys_status", 5'd12, 32'h0040_0002);

        // 3: nested ov keeps EPC/BD, then eret
        exc_req = 7'b000_0001; exc_pc = 32'h0000_0080;
        step();
        exc_req = 7'h0;
        rd_check("nest_epc", 5'd14, 32'hBFC0_00FC);
        rd(5'd13, rv);
        check("nest_code", {27'b0, rv[6:2]}, 32'h0c);
        check("nest_bd", {31'b0, rv[31]}, 32'h1);
        eret = 1'b1;
        #1;
        check("eret_flush", {31'b0, flush}, 32'h1);
        check("eret_pc", flush_pc, 32'hBFC0_00FC);
        step();
        eret = 1'b0;
        rd_check("eret_status", 5'd12, 32'h0040_0000);

        // 4: timer compare match and acknowledge
        mtc0(5'd9, 32'h0);
        mtc0(5'd11, 32'h5);
        mtc0(5'd9, 32'h0);
        repeat (10) step();
        rd_check("tmr_count5", 5'd9, 32'h5);
        rd(5'd13, rv);
        check("tmr_ti_early", {31'b0, rv[30]}, 32'h0);
        step();
        rd(5'd13, rv);
        check("tmr_ti", {31'b0, rv[30]}, 32'h1);
        check("tmr_ip7", {31'b0, rv[15]}, 32'h1);
        mtc0(5'd11, 32'h100);
        rd(5'd13, rv);
        check("tmr_ack_ti", {31'b0, rv[30]}, 32'h0);
        check("tmr_ack_ip7", {31'b0, rv[15]}, 32'h0);

        // 5: hardware interrupt latency, dropped same-cycle Status write
        mtc0(5'd12, 32'h0000_0401);
        rd_check("int_status", 5'd12, 32'h0040_0401);
        hw_int = 6'h01;
        #1;
        check("int_lat0", {31'b0, int_pending}, 32'h0);
        step();
        check("int_lat1", {31'b0, int_pending}, 32'h1);
        rd(5'd13, rv);
        check("int_ip2", {31'b0, rv[10]}, 32'h1);
        exc_req = 7'b100_0000; exc_pc = 32'h8000_1000;
        cp0_addr = 5'd12; cp0_wdata = 32'h0000_FF00; cp0_wen = 1'b1;
        step();
        exc_req = 7'h0; cp0_wen = 1'b0;
        rd_check("int_drop_status", 5'd12, 32'h0040_0403);
        rd_check("int_epc", 5'd14, 32'h8000_1000);
        check("int_masked", {31'b0, int_pending}, 32'h0);
        eret = 1'b1;
        step();
        eret = 1'b0;
        check("int_after_eret", {31'b0, int_pending}, 32'h1);
        hw_int = 6'h0;
        step();

        // 6: ades captures BadVAddr, same-cycle EPC write ignored
        exc_req = 7'b001_0000; bad_vaddr = 32'h8000_1233; exc_pc = 32'h8000_2000;
        cp0_addr = 5'd14; cp0_wdata = 32'h1234_5678; cp0_wen = 1'b1;
        step();
        exc_req = 7'h0; cp0_wen = 1'b0;
        rd_check("ades_bva", 5'd8, 32'h8000_1233);
        rd_check("ades_epc", 5'd14, 32'h8000_2000);
        rd(5'd13, rv);
        check("ades_code", {27'b0, rv[6:2]}, 32'h05);
        eret = 1'b1;
        step();
        eret = 1'b0;

        // int outranks adel: BadVAddr must hold
        exc_req = 7'b110_0000; bad_vaddr = 32'hDEAD_BEEF;
        step();
        exc_req = 7'h0;
        rd_check("intadel_bva", 5'd8, 32'h8000_1233);
        rd(5'd13, rv);
        check("intadel_code", {27'b0, rv[6:2]}, 32'h00);
        eret = 1'b1;
        step();
        eret = 1'b0;

        mtc0(5'd14, 32'h1234_5678);
        rd_check("mtc0_epc", 5'd14, 32'h1234_5678);
        rd_check("unimpl", 5'd0, 32'h0);

        // Count wrap-around
        mtc0(5'd9, 32'hFFFF_FFFF);
        step();
        rd_check("wrap_pre", 5'd9, 32'hFFFF_FFFF);
        step();
        rd_check("wrap_post", 5'd9, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
